blue_motion_ctrl: RTL and testbench
===================================

Name: blue_motion_ctrl

Overview:
- Produces everything the blue-character display path consumes: the character state word `blue_state[2:0]` and the sprite ROM pixel address `blue[13:0]`.
- Tracks the character's top-left position (x, y) from key inputs and map collision flags. Position updates once per game tick.
- Maps the VGA scan position onto the 47-pixel-wide sprite to produce the ROM address plus an in-sprite qualifier for the pixel mux.

Parameters:
- X_INIT, 100: reset x (pixels).
- Y_INIT, 300: reset y (pixels).
- WALK_STEP, 2: horizontal pixels moved per tick while walking.
- JUMP_V, 12: initial upward speed (pixels/tick).
- GRAVITY, 1: speed change per tick.
- VMAX_FALL, 8: terminal fall speed.
- X_MAX, 593: largest legal x (640-47).
- Y_MAX, 420: largest legal y (480-60).
- SPR_W, 47: sprite width.
- SPR_H, 60: sprite height.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-tick pulse
- key_left  in  1  left key, level
- key_right  in  1  right key, level
- key_jump  in  1  jump key, level
- ground_hit  in  1  feet on a platform
- head_hit  in  1  head against a ceiling
- wall_left  in  1  blocked on the left
- wall_right  in  1  blocked on the right
- h_cnt  in  10  VGA column
- v_cnt  in  9  VGA row
- pos_x  out  10  character x
- pos_y  out  9  character y
- blue_state  out  3  bit0 facing (0 left, 1 right); bit1 in air; bit2 moving
- blue  out  14  sprite ROM address
- in_sprite  out  1  scan pixel lies inside the sprite

Behaviour:
- Reset (async, rst_n=0):
  - pos_x=X_INIT, pos_y=Y_INIT, FSM=GROUND, vy=0, dir=1, move=0.
  - blue_state=3'b001, blue=0, in_sprite=0, jump_prev=0.
- All motion state changes only in cycles with tick=1. It holds otherwise.
- Horizontal, evaluated every tick:
  - key_right & !key_left: dir=1, move=1. x += WALK_STEP, unless wall_right. Result is clamped to X_MAX.
  - key_left & !key_right: dir=0, move=1. x -= WALK_STEP, unless wall_left. Result is clamped to 0, with no unsigned wrap.
  - Both keys or neither key: move=0, dir holds.
  - move=1 is still reported while blocked by a wall.
- Jump edge: jump_edge = key_jump & !jump_prev. jump_prev samples key_jump only on ticks.
- FSM state GROUND:
  - jump_edge: go to RISE, vy=JUMP_V, y unchanged this tick. Jump wins over every other event.
  - else !ground_hit: go to FALL, vy=0.
- FSM state RISE:
  - y -= vy, saturating at 0.
  - If head_hit, or vy<=GRAVITY: go to FALL, vy=0.
  - Otherwise vy -= GRAVITY.
- FSM state FALL:
  - ground_hit: go to GROUND, vy=0, y holds.
  - Otherwise y_new = y+vy. If y_new>=Y_MAX: y=Y_MAX and go to GROUND. Otherwise y=y_new.
  - vy = min(vy+GRAVITY, VMAX_FALL).
- blue_state = {move, state!=GROUND, dir}. It is registered and updated on the same tick as position.
- Address path, every clk, 1-cycle latency:
  - col = h_cnt-pos_x, row = v_cnt-pos_y, using 11-bit signed arithmetic.
  - in_sprite = 0<=col<SPR_W and 0<=row<SPR_H.
  - blue = row*SPR_W+col when in_sprite, else 0.
  - Uses the pos_x/pos_y values before any same-cycle update.
- Arithmetic: vy is 5-bit unsigned. The largest address, SPR_W*SPR_H-1 = 2819, fits in 14 bits.
- Reset mid-jump returns to the reset values immediately.

Optional Feature:
- Macro: BLUE_DOUBLE_JUMP_EN.
- When defined:
  - A 1-bit air_jump_avail flag is set on entry to GROUND, and set by reset.
  - In RISE or FALL, a jump_edge with the flag set reloads vy=JUMP_V, enters RISE and clears the flag. This takes priority over head_hit and ground_hit.
- When undefined: jump_edge is ignored in RISE and FALL, and the flag logic is absent.

Test Plan:
- Reset, then 10 ticks with no keys and ground_hit=1 -> pos=(100,300), blue_state=001, vy=0.
- key_left held for 5 ticks with ground_hit=1 -> pos_x=90, blue_state=100. Release -> 000, pos_x stays 90.
- Jump: key_jump pulse, ground_hit=1 on the first tick only, then ground_hit=0 -> RISE for 12 ticks, peak pos_y=222, then FALL. Set ground_hit=1 -> GROUND, bit1=0.
- head_hit asserted on the 3rd RISE tick -> pos_y=267 and FSM=FALL.
- Walls and clamps:
  - pos_x=592 with key_right -> 593, and stays 593.
  - wall_right=1 -> x holds and bit2=1.
  - Falling with ground_hit=0 -> y clamps to 420 and enters GROUND.
- Address: pos=(100,300), h_cnt=146, v_cnt=359 -> next cycle blue=2819, in_sprite=1. h_cnt=147 -> blue=0, in_sprite=0.
- With BLUE_DOUBLE_JUMP_EN defined: a second jump edge during FALL -> RISE with vy=12. A third edge is ignored.

Source files
------------

// File: rtl/blue_motion_ctrl.sv
// blue_motion_ctrl: blue-character position/jump FSM plus sprite ROM addressing.
// Ports: clk, rst_n, tick, key_*, *_hit, wall_*, h_cnt, v_cnt -> pos_x, pos_y, blue_state, blue, in_sprite.
// Optional: define BLUE_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module blue_motion_ctrl #(
  parameter int X_INIT    = 100,
  parameter int Y_INIT    = 300,
  parameter int WALK_STEP = 2,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1,
  parameter int VMAX_FALL = 8,
  parameter int X_MAX     = 593,
  parameter int Y_MAX     = 420,
  parameter int SPR_W     = 47,
  parameter int SPR_H     = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  input  logic        ground_hit,
  input  logic        head_hit,
  input  logic        wall_left,
  input  logic        wall_right,
  input  logic [9:0]  h_cnt,
  input  logic [8:0]  v_cnt,
  output logic [9:0]  pos_x,
  output logic [8:0]  pos_y,
  output logic [2:0]  blue_state,
  output logic [13:0] blue,
  output logic        in_sprite
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  localparam logic [9:0]  XI   = 10'(X_INIT);
  localparam logic [8:0]  YI   = 9'(Y_INIT);
  localparam logic [10:0] STEP = 11'(WALK_STEP);
  localparam logic [10:0] XMAX = 11'(X_MAX);
  localparam logic [9:0]  YMAX = 10'(Y_MAX);
  localparam logic [4:0]  JV   = 5'(JUMP_V);
  localparam logic [4:0]  G    = 5'(GRAVITY);
  localparam logic [5:0]  VMAX = 6'(VMAX_FALL);
  localparam logic [10:0] SW   = 11'(SPR_W);
  localparam logic [10:0] SH   = 11'(SPR_H);
  localparam logic [13:0] SW14 = 14'(SPR_W);

  state_t      st, st_n;
  logic [9:0]  x_n;
  logic [8:0]  y_n;
  logic [4:0]  vy, vy_n;
  logic        dir, dir_n;
  logic        move, move_n;
  logic        jump_prev;
  logic        jump_edge;
  logic [10:0] xs;
  logic [9:0]  ys;
  logic [5:0]  vf;

`ifdef BLUE_DOUBLE_JUMP_EN
  logic        avail, avail_n;
`endif

  assign jump_edge = key_jump & ~jump_prev;
  assign xs        = {1'b0, pos_x} + STEP;
  assign ys        = {1'b0, pos_y} + {5'b0, vy};
  assign vf        = {1'b0, vy} + {1'b0, G};

  always_comb begin
    st_n   = st;
    x_n    = pos_x;
    y_n    = pos_y;
    vy_n   = vy;
    dir_n  = dir;
    move_n = 1'b0;
`ifdef BLUE_DOUBLE_JUMP_EN
    avail_n = avail;
`endif

    unique case (1'b1)
      key_right & ~key_left: begin
        dir_n  = 1'b1;
        move_n = 1'b1;
        if (!wall_right)
          x_n = (xs > XMAX) ? XMAX[9:0] : xs[9:0];
      end
      key_left & ~key_right: begin
        dir_n  = 1'b0;
        move_n = 1'b1;
        if (!wall_left)
          x_n = ({1'b0, pos_x} < STEP) ? 10'd0
                : pos_x - STEP[9:0];
      end
      default: move_n = 1'b0;
    endcase

    unique case (st)
      GROUND: begin
        if (jump_edge) begin
          st_n = RISE;
          vy_n = JV;
        end else if (!ground_hit) begin
          st_n = FALL;
          vy_n = 5'd0;
        end
      end
      RISE: begin
        y_n = (pos_y < {4'b0, vy}) ? 9'd0
              : pos_y - {4'b0, vy};
        if (head_hit || vy <= G) begin
          st_n = FALL;
          vy_n = 5'd0;
        end else begin
          vy_n = vy - G;
        end
      end
      FALL: begin
        if (ground_hit) begin
          st_n = GROUND;
          vy_n = 5'd0;
        end else if (ys >= YMAX) begin
          // Landing on the floor: vy is meaningless on the ground.
          y_n  = YMAX[8:0];
          st_n = GROUND;
          vy_n = 5'd0;
        end else begin
          y_n  = ys[8:0];
          vy_n = (vf > VMAX) ? VMAX[4:0] : vf[4:0];
        end
      end
      default: begin
        st_n = GROUND;
        vy_n = 5'd0;
      end
    endcase

`ifdef BLUE_DOUBLE_JUMP_EN
    // Air jump overrides head/ground events; y holds on the reload tick.
    if (st != GROUND && jump_edge && avail) begin
      st_n    = RISE;
      vy_n    = JV;
      y_n     = pos_y;
      avail_n = 1'b0;
    end
    if (st_n == GROUND)
      avail_n = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= GROUND;
      pos_x      <= XI;
      pos_y      <= YI;
      vy         <= 5'd0;
      dir        <= 1'b1;
      move       <= 1'b0;
      jump_prev  <= 1'b0;
      blue_state <= 3'b001;
    end else if (tick) begin
      st         <= st_n;
      pos_x      <= x_n;
      pos_y      <= y_n;
      vy         <= vy_n;
      dir        <= dir_n;
      move       <= move_n;
      jump_prev  <= key_jump;
      blue_state <= {move_n, st_n != GROUND, dir_n};
    end
  end

`ifdef BLUE_DOUBLE_JUMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      avail <= 1'b1;
    else if (tick)
      avail <= avail_n;
  end
`endif

  logic [10:0] col, row;
  logic        hit;
  logic [13:0] addr;

  assign col  = {1'b0, h_cnt} - {1'b0, pos_x};
  assign row  = {2'b0, v_cnt} - {2'b0, pos_y};
  assign hit  = !col[10] && (col < SW) &&
                !row[10] && (row < SH);
  assign addr = {8'b0, row[5:0]} * SW14
              + {8'b0, col[5:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blue      <= 14'd0;
      in_sprite <= 1'b0;
    end else begin
      blue      <= hit ? addr : 14'd0;
      in_sprite <= hit;
    end
  end

endmodule

// File: tb/tb_blue_motion_ctrl.sv
// tb_blue_motion_ctrl: directed self-checking bench for blue_motion_ctrl.
// Ticks are driven on falling edges; outputs are sampled on falling edges.
module tb_blue_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic        key_jump = 1'b0;
  logic        ground_hit = 1'b1;
  logic        head_hit = 1'b0;
  logic        wall_left = 1'b0;
  logic        wall_right = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [8:0]  v_cnt = '0;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [2:0]  blue_state;
  logic [13:0] blue;
  logic        in_sprite;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fall;

  blue_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_jump   (key_jump),
    .ground_hit (ground_hit),
    .head_hit   (head_hit),
    .wall_left  (wall_left),
    .wall_right (wall_right),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .blue_state (blue_state),
    .blue       (blue),
    .in_sprite  (in_sprite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_x", pos_x, 100);
    chk("rst_y", pos_y, 300);
    chk("rst_bs", blue_state, 1);
    chk("rst_blue", blue, 0);
    chk("rst_in", in_sprite, 0);
    rst_n = 1'b1;

    tk(10);
    chk("idle_x", pos_x, 100);
    chk("idle_y", pos_y, 300);
    chk("idle_bs", blue_state, 3'b001);

    h_cnt = 10'd146; v_cnt = 9'd359;
    @(negedge clk);
    chk("adr_last", blue, 2819);
    chk("in_last", in_sprite, 1);
    h_cnt = 10'd147;
    @(negedge clk);
    chk("adr_right", blue, 0);
    chk("in_right", in_sprite, 0);
    h_cnt = 10'd100; v_cnt = 9'd300;
    @(negedge clk);
    chk("adr_org", blue, 0);
    chk("in_org", in_sprite, 1);
    h_cnt = 10'd99;
    @(negedge clk);
    chk("in_negcol", in_sprite, 0);
    h_cnt = 10'd101; v_cnt = 9'd301;
    @(negedge clk);
    chk("adr_11", blue, 48);

    key_left = 1'b1;
    tk(5);
    chk("left_x", pos_x, 90);
    chk("left_bs", blue_state, 3'b100);
    key_left = 1'b0;
    tk(1);
    chk("rel_x", pos_x, 90);
    chk("rel_bs", blue_state, 3'b000);

    key_jump = 1'b1;
    tk(1);
    chk("jmp_y0", pos_y, 300);
    chk("jmp_bs", blue_state, 3'b010);
    key_jump = 1'b0;
    ground_hit = 1'b0;
    tk(1);
    chk("rise1_y", pos_y, 288);
    tk(11);
    chk("peak_y", pos_y, 222);
    chk("peak_air", blue_state[1], 1);
    tk(1);
    chk("fall1_y", pos_y, 222);
    ground_hit = 1'b1;
    tk(1);
    chk("land_y", pos_y, 222);
    chk("land_bs", blue_state, 3'b000);

    key_jump = 1'b1;
    tk(1);
    key_jump = 1'b0;
    ground_hit = 1'b0;
    tk(2);
    head_hit = 1'b1;
    tk(1);
    head_hit = 1'b0;
    chk("head_y", pos_y, 189);
    tk(1);
    chk("head_fall", pos_y, 189);
    chk("head_air", blue_state[1], 1);

    n_fall = 1;
    while (blue_state[1] && n_fall < 80) begin
      tk(1);
      n_fall++;
    end
    chk("floor_n", n_fall, 34);
    chk("floor_y", pos_y, 420);
    chk("floor_bs", blue_state[1], 0);
    ground_hit = 1'b1;

    wall_right = 1'b1;
    key_right = 1'b1;
    tk(2);
    chk("wallr_x", pos_x, 90);
    chk("wallr_bs", blue_state, 3'b101);
    wall_right = 1'b0;
    tk(251);
    chk("right_x", pos_x, 592);
    tk(1);
    chk("clampr1", pos_x, 593);
    tk(1);
    chk("clampr2", pos_x, 593);
    key_right = 1'b0;

    key_left = 1'b1;
    wall_left = 1'b1;
    tk(1);
    chk("walll_x", pos_x, 593);
    chk("walll_bs", blue_state, 3'b100);
    wall_left = 1'b0;
    tk(296);
    chk("left_1", pos_x, 1);
    tk(1);
    chk("clampl1", pos_x, 0);
    tk(1);
    chk("clampl2", pos_x, 0);
    key_left = 1'b0;
    tk(1);

    key_jump = 1'b1;
    tk(1);
    key_jump = 1'b0;
    ground_hit = 1'b0;
    tk(12);
    chk("j2_peak", pos_y, 342);
    tk(1);
    chk("j2_f1", pos_y, 342);
    key_jump = 1'b1;
    tk(1);
`ifdef BLUE_DOUBLE_JUMP_EN
    chk("dj_y", pos_y, 342);
    chk("dj_bs", blue_state, 3'b010);
    key_jump = 1'b0;
    tk(1);
    chk("dj_rise", pos_y, 330);
    key_jump = 1'b1;
    tk(1);
    chk("dj_third", pos_y, 319);
`else
    chk("nodj_y", pos_y, 343);
    key_jump = 1'b0;
    tk(1);
    chk("nodj_f", pos_y, 345);
    key_jump = 1'b1;
    tk(1);
    chk("nodj_3", pos_y, 348);
`endif
    key_jump = 1'b0;
    tk(1);

    rst_n = 1'b0;
    #1;
    chk("arst_x", pos_x, 100);
    chk("arst_y", pos_y, 300);
    chk("arst_bs", blue_state, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
